oam_dma: RTL and testbench
==========================

Name: oam_dma

Overview:
- Sprite DMA engine for the CPU bus: on a CPU write to $4014, halts the CPU and copies 256 bytes from page $XX00-$XXFF into PPU OAM through $2004 writes.
- Sits between the CPU bus arbiter and the 2 KB CPU work RAM, whose read data is registered with one-cycle latency, and the PPU register port.
- Its typical source is the work-RAM page $0200.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers a transfer.
- OAM_DATA_ADDR, 16'h2004, PPU OAMDATA address; informational, driven as the destination on oam_addr.
- XFER_LEN, 256, bytes per transfer; must be a power of two, max 256.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cpu_ce  in  1  CPU-cycle enable; all state advances only on clk edges with cpu_ce=1.
- cpu_addr  in  16  CPU bus address.
- cpu_wdata  in  8  CPU write data.
- cpu_we  in  1  CPU write strobe.
- cpu_halt  out  1  CPU stall request.
- dma_re  out  1  DMA owns the bus and reads dma_addr this cycle.
- dma_addr  out  16  read address, {page, idx}.
- dma_rdata  in  8  bus read data, valid one CPU cycle after dma_re (registered RAM).
- oam_we  out  1  write strobe to the PPU.
- oam_addr  out  16  constant OAM_DATA_ADDR.
- oam_wdata  out  8  byte to write.
- done  out  1  one-clk pulse at the end of a transfer.

Behaviour:
- Reset (asynchronous, any time including mid-transfer):
  - state=IDLE, page=0, idx=0, parity=0.
  - All outputs 0 except oam_addr.
  - An in-flight transfer is abandoned.
- Parity flop toggles on every cpu_ce, in every state.
- Trigger condition: cpu_ce & cpu_we & cpu_addr==DMA_REG_ADDR while in IDLE. On that edge: page<=cpu_wdata, idx<=0, state<=HALT.
- Triggers outside IDLE are ignored. The CPU is halted, so this only occurs in benches.
- States, each lasting one cpu_ce cycle:
  - IDLE: cpu_halt=0.
  - HALT: cpu_halt=1, no bus activity. Next state is GET if parity at that edge becomes 0, else ALIGN.
  - ALIGN: cpu_halt=1, idle. Next state is GET.
  - GET: cpu_halt=1, dma_re=1, dma_addr={page,idx}. Next state is PUT.
  - PUT: cpu_halt=1, oam_we=1, oam_wdata=dma_rdata (combinational pass-through).
    - If idx==XFER_LEN-1: next state IDLE, done=1 for the following clk.
    - Else: idx<=idx+1, next state GET.
- Output decoding: outputs are decoded from registered state and are held stable between cpu_ce pulses.
- GET always lands on parity 0 and PUT on parity 1.
- Halted cycle count:
  - 513 (1 HALT + 512) when the trigger write lands on a parity-0 cycle.
  - 514 with ALIGN when it lands on a parity-1 cycle.
- Wrap and addressing:
  - idx is an 8-bit counter; it never wraps within a transfer.
  - Page $FF reads $FF00-$FFFF; dma_addr never carries into bit 16.
- The block holds state with cpu_ce=0 indefinitely; no timeouts.

Optional Feature:
- Macro: OAM_DMA_ODD_ALIGN_EN.
- Defined: ALIGN insertion as above (hardware-accurate 513/514 cycles).
- Undefined:
  - HALT always goes directly to GET; transfers are always 513 cycles.
  - The parity flop and ALIGN state are removed.
  - GET/PUT parity is unconstrained.

Test Plan:
1. Reset, preload RAM $0200+i = i^8'hA5. Write $02 to $4014 on the parity-0 cycle -> cpu_halt high 513 ce cycles; 256 oam_we pulses with oam_wdata=i^A5 in order; done pulses once; cpu_halt low after.
2. Same but trigger on the parity-1 cycle -> 514 halted cycles. First dma_re occurs one cycle later than in test 1, with dma_addr=$0200.
3. cpu_ce asserted every 3rd clk during a transfer -> identical oam_wdata sequence; outputs stable across gaps; cycle counts in ce units unchanged.
4. Page $FF -> dma_addr spans $FF00-$FFFF, last dma_addr=$FFFF, then IDLE.
5. Assert rst at byte 100 mid-PUT -> next clk: all outputs 0, IDLE. A new $4014 write of $03 restarts from $0300.
6. Second $4014 write during transfer -> ignored; page unchanged; exactly 256 oam_we pulses.

Source files
------------

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to DMA_REG_ADDR halts the CPU and copies one page into PPU OAM.
// Build option OAM_DMA_ODD_ALIGN_EN adds the parity flop and ALIGN state (513/514-cycle halts).
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    output logic        cpu_halt,
    output logic        dma_re,
    output logic [15:0] dma_addr,
    input  logic [7:0]  dma_rdata,
    output logic        oam_we,
    output logic [15:0] oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        done
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
`ifdef OAM_DMA_ODD_ALIGN_EN
        S_ALIGN,
`endif
        S_GET,
        S_PUT
    } state_t;

    state_t     state, state_next;
    logic [7:0] page, page_next;
    logic [7:0] idx, idx_next;
    logic       last_put;

    assign last_put = (state == S_PUT) && (idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            page  <= 8'h00;
            idx   <= 8'h00;
        end else if (cpu_ce) begin
            state <= state_next;
            page  <= page_next;
            idx   <= idx_next;
        end
    end

`ifdef OAM_DMA_ODD_ALIGN_EN
    // Mirrors the CPU get/put cycle phase; runs regardless of state.
    logic parity;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            parity <= 1'b0;
        else if (cpu_ce)
            parity <= ~parity;
    end
`endif

    // done lasts exactly one clk even when cpu_ce is sparse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            done <= 1'b0;
        else
            done <= cpu_ce && last_put;
    end

    always_comb begin
        state_next = state;
        page_next  = page;
        idx_next   = idx;
        case (state)
            S_IDLE: begin
                if (cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
                    page_next  = cpu_wdata;
                    idx_next   = 8'h00;
                    state_next = S_HALT;
                end
            end
            S_HALT: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
                // parity flips on this edge; GET must start on the new parity 0
                state_next = parity ? S_GET : S_ALIGN;
`else
                state_next = S_GET;
`endif
            end
`ifdef OAM_DMA_ODD_ALIGN_EN
            S_ALIGN: state_next = S_GET;
`endif
            S_GET: state_next = S_PUT;
            S_PUT: begin
                if (idx == LAST_IDX) begin
                    state_next = S_IDLE;
                end else begin
                    idx_next   = idx + 8'h01;
                    state_next = S_GET;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign cpu_halt  = (state != S_IDLE);
    assign dma_re    = (state == S_GET);
    assign dma_addr  = (state == S_GET) ? {page, idx} : 16'h0000;
    assign oam_we    = (state == S_PUT);
    assign oam_wdata = (state == S_PUT) ? dma_rdata : 8'h00;
    assign oam_addr  = OAM_DATA_ADDR;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: parity-dependent halt length, sparse cpu_ce, page $FF,
// mid-transfer reset and ignored re-trigger, checked against a simple RAM model.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_halt;
    logic        dma_re;
    logic [15:0] dma_addr;
    logic [7:0]  dma_rdata;
    logic        oam_we;
    logic [15:0] oam_addr;
    logic [7:0]  oam_wdata;
    logic        done;

    oam_dma dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_ce    (cpu_ce),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_halt  (cpu_halt),
        .dma_re    (dma_re),
        .dma_addr  (dma_addr),
        .dma_rdata (dma_rdata),
        .oam_we    (oam_we),
        .oam_addr  (oam_addr),
        .oam_wdata (oam_wdata),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    always @(posedge clk)
        if (cpu_ce && dma_re)
            dma_rdata <= mem[dma_addr];

`ifdef OAM_DMA_ODD_ALIGN_EN
    localparam int ODD_HALT  = 514;
    localparam int ODD_FIRST = 3;
`else
    localparam int ODD_HALT  = 513;
    localparam int ODD_FIRST = 2;
`endif

    int total = 0;
    int bad   = 0;
    int ce_total = 0;
    logic [15:0] last_addr;

    logic        s_halt, s_re, s_we, s_done;
    logic [15:0] s_addr;
    logic [7:0]  s_wdata;

    function automatic logic [7:0] exp_byte(input logic [7:0] pg, input logic [7:0] i);
        if (pg == 8'h02)
            return i ^ 8'hA5;
        return i ^ pg ^ 8'h3C;
    endfunction

    task automatic step(input logic ce, input logic we, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_ce    = ce;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        #1;
        s_halt  = cpu_halt;
        s_re    = dma_re;
        s_we    = oam_we;
        s_done  = done;
        s_addr  = dma_addr;
        s_wdata = oam_wdata;
        if (ce)
            ce_total++;
    endtask

    task automatic align_parity(input int want);
        if ((ce_total % 2) != want)
            step(1'b1, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic run_xfer(input logic [7:0] pg, input int period, input int inject_at,
                            input int abort_at, output int halted, output int first_re,
                            output int n_we);
        int ce_k, n_re;
        logic ce, inj, prev_ce, fin;
        logic        p_halt, p_re, p_we;
        logic [15:0] p_addr;
        logic [7:0]  p_wdata;
        halted = 0; first_re = -1; n_we = 0; n_re = 0; ce_k = 0; fin = 1'b0;
        step(1'b1, 1'b1, 16'h4014, pg);
        prev_ce = 1'b1;
        p_halt = s_halt; p_re = s_re; p_we = s_we; p_addr = s_addr; p_wdata = s_wdata;
        for (int k = 1; k < 3000 && !fin; k++) begin
            ce  = ((k % period) == 0);
            inj = ce && ((ce_k + 1) == inject_at);
            step(ce, inj, inj ? 16'h4014 : 16'h0000, inj ? 8'h77 : 8'h00);
            if (!ce && !prev_ce) begin
                total++;
                if ({s_halt, s_re, s_we, s_addr, s_wdata} !== {p_halt, p_re, p_we, p_addr, p_wdata}) begin
                    bad++;
                    $display("FAIL stable_gap k=%0d got=%h want=%h", k,
                             {s_halt, s_re, s_we, s_addr, s_wdata}, {p_halt, p_re, p_we, p_addr, p_wdata});
                end
            end
            if (ce) begin
                ce_k++;
                if (s_halt)
                    halted++;
                if (s_re) begin
                    if (first_re < 0)
                        first_re = ce_k;
                    total++;
                    if (s_addr !== {pg, n_re[7:0]}) begin
                        bad++;
                        $display("FAIL dma_addr n=%0d got=%h want=%h", n_re, s_addr, {pg, n_re[7:0]});
                    end
                    last_addr = s_addr;
                    n_re++;
                end
                if (s_we) begin
                    total++;
                    if (s_wdata !== exp_byte(pg, n_we[7:0])) begin
                        bad++;
                        $display("FAIL oam_wdata n=%0d got=%h want=%h", n_we, s_wdata, exp_byte(pg, n_we[7:0]));
                    end
                    n_we++;
                    if (abort_at >= 0 && n_we == abort_at + 1)
                        return;
                end
            end
            if (s_done)
                fin = 1'b1;
            p_halt = s_halt; p_re = s_re; p_we = s_we; p_addr = s_addr; p_wdata = s_wdata;
            prev_ce = ce;
        end
        total++;
        if (!fin) begin
            bad++;
            $display("FAIL timeout page=%h got=no_done want=done", pg);
        end else begin
            step(1'b0, 1'b0, 16'h0000, 8'h00);
            if (s_done !== 1'b0 || s_halt !== 1'b0) begin
                bad++;
                $display("FAIL done_pulse got=done%b halt%b want=done0 halt0", s_done, s_halt);
            end
        end
    endtask

    task automatic check_xfer(input string name, input int halted, input int want_halted,
                              input int first_re, input int want_first, input int n_we);
        total++;
        if (halted !== want_halted) begin
            bad++;
            $display("FAIL %s_halted got=%0d want=%0d", name, halted, want_halted);
        end
        total++;
        if (first_re !== want_first) begin
            bad++;
            $display("FAIL %s_first_re got=%0d want=%0d", name, first_re, want_first);
        end
        total++;
        if (n_we !== 256) begin
            bad++;
            $display("FAIL %s_oam_we_count got=%0d want=256", name, n_we);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; cpu_ce = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({cpu_halt, dma_re, oam_we, done, dma_addr, oam_wdata} !== 28'h0 || oam_addr !== 16'h2004) begin
            bad++;
            $display("FAIL reset_outputs got=%h/%h want=0/2004",
                     {cpu_halt, dma_re, oam_we, done, dma_addr, oam_wdata}, oam_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        ce_total = 0;
    endtask

    task automatic test_even;
        int h, f, n;
        align_parity(0);
        run_xfer(8'h02, 1, -1, -1, h, f, n);
        check_xfer("even", h, 513, f, 2, n);
    endtask

    task automatic test_odd;
        int h, f, n;
        align_parity(1);
        run_xfer(8'h02, 1, -1, -1, h, f, n);
        check_xfer("odd", h, ODD_HALT, f, ODD_FIRST, n);
    endtask

    task automatic test_sparse_ce;
        int h, f, n;
        align_parity(0);
        run_xfer(8'h02, 3, -1, -1, h, f, n);
        check_xfer("sparse", h, 513, f, 2, n);
    endtask

    task automatic test_page_ff;
        int h, f, n;
        align_parity(0);
        run_xfer(8'hFF, 1, -1, -1, h, f, n);
        check_xfer("page_ff", h, 513, f, 2, n);
        total++;
        if (last_addr !== 16'hFFFF) begin
            bad++;
            $display("FAIL page_ff_last_addr got=%h want=ffff", last_addr);
        end
    endtask

    task automatic test_reset_mid;
        int h, f, n;
        align_parity(0);
        run_xfer(8'h02, 1, -1, 100, h, f, n);
        rst = 1'b1;
        #1;
        total++;
        if ({cpu_halt, dma_re, oam_we, dma_addr, oam_wdata} !== 27'h0 || oam_addr !== 16'h2004) begin
            bad++;
            $display("FAIL mid_reset_async got=%h want=0", {cpu_halt, dma_re, oam_we, dma_addr, oam_wdata});
        end
        @(posedge clk);
        #1;
        total++;
        if ({cpu_halt, dma_re, oam_we, done} !== 4'h0) begin
            bad++;
            $display("FAIL mid_reset_idle got=%b want=0000", {cpu_halt, dma_re, oam_we, done});
        end
        @(negedge clk);
        rst = 1'b0;
        cpu_ce = 1'b0;
        ce_total = 0;
        run_xfer(8'h03, 1, -1, -1, h, f, n);
        check_xfer("restart", h, 513, f, 2, n);
    endtask

    task automatic test_retrigger;
        int h, f, n;
        align_parity(0);
        run_xfer(8'h02, 1, 50, -1, h, f, n);
        check_xfer("retrigger", h, 513, f, 2, n);
        total++;
        if (last_addr !== 16'h02FF) begin
            bad++;
            $display("FAIL retrigger_last_addr got=%h want=02ff", last_addr);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            logic [15:0] av;
            av = a[15:0];
            mem[a] = exp_byte(av[15:8], av[7:0]);
        end
        test_reset;
        test_even;
        test_odd;
        test_sparse_ce;
        test_page_ff;
        test_reset_mid;
        test_retrigger;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
